// File: rtl/ysyx_040750_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_040750_div_ctrl_pkg
//  Brief    : Shared types and constants for the divide controller.
//  Revision : 1.0
// ============================================================================
package ysyx_040750_div_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // div_op = {word, unsigned, rem}
  localparam int unsigned c_OP_REM  = 0;
  localparam int unsigned c_OP_UNS  = 1;
  localparam int unsigned c_OP_WORD = 2;

  localparam logic [63:0] c_ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_MIN64  = 64'h8000_0000_0000_0000;
  localparam logic [31:0] c_MIN32  = 32'h8000_0000;

  function automatic logic [63:0] word_fix(input logic word, input logic [63:0] v);
    return word ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_040750_radix2_div.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_040750_radix2_div
//  Brief    : 64-bit radix-2 restoring divider, 64 iterations, sign fix-up at output.
//  Revision : 1.0
// ============================================================================
module ysyx_040750_radix2_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_valid,
  input  logic        is_signed,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        Q_valid,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);

  logic        w_dend_neg;
  logic        w_dsor_neg;
  logic [63:0] w_dend_abs;
  logic [63:0] w_dsor_abs;
  logic [64:0] w_sub;

  logic [63:0] r_rem;
  logic [63:0] r_quo;
  logic [63:0] r_dsor;
  logic [6:0]  r_cnt;
  logic        r_run;

  assign w_dend_neg = is_signed & dividend[63];
  assign w_dsor_neg = is_signed & divisor[63];
  assign w_dend_abs = w_dend_neg ? (~dividend + 64'd1) : dividend;
  assign w_dsor_abs = w_dsor_neg ? (~divisor + 64'd1) : divisor;
  // Partial remainder stays below the divisor, so a 65-bit trial covers the shift.
  assign w_sub      = {r_rem, r_quo[63]} - {1'b0, r_dsor};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dsor <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
    end else if (div_valid) begin
      r_rem  <= '0;
      r_quo  <= w_dend_abs;
      r_dsor <= w_dsor_abs;
      r_cnt  <= 7'd64;
      r_run  <= 1'b1;
    end else if (r_run) begin
      if (r_cnt != 7'd0) begin
        if (!w_sub[64]) begin
          r_rem <= w_sub[63:0];
          r_quo <= {r_quo[62:0], 1'b1};
        end else begin
          r_rem <= {r_rem[62:0], r_quo[63]};
          r_quo <= {r_quo[62:0], 1'b0};
        end
        r_cnt <= r_cnt - 7'd1;
      end else begin
        r_run <= 1'b0;
      end
    end
  end

  assign Q_valid   = r_run & (r_cnt == 7'd0);
  assign quotient  = (w_dend_neg ^ w_dsor_neg) ? (~r_quo + 64'd1) : r_quo;
  assign remainder = w_dend_neg ? (~r_rem + 64'd1) : r_rem;

endmodule
`default_nettype wire

// File: rtl/ysyx_040750_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_040750_div_ctrl
//  Brief    : Request/result handshake, special-case handling and word fix-up
//             around the radix-2 divider.
//  Revision : 1.0
// ============================================================================
module ysyx_040750_div_ctrl
  import ysyx_040750_div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  div_op,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        busy
);

  div_state_t r_state;
  div_state_t w_next;

  logic [2:0]  r_op;
  logic [63:0] r_src1;
  logic [63:0] r_src2;
  logic [63:0] r_result;
  logic        r_div_valid;
  logic        r_flush;

  logic        w_word;
  logic        w_uns;
  logic [63:0] w_ext1;
  logic [63:0] w_ext2;
  logic        w_div_zero;
  logic        w_ovf;
  logic        w_special;
  logic [63:0] w_spec_sel;
  logic        w_accept;
  logic        w_div_rst;
  logic        w_q_valid;
  logic [63:0] w_quotient;
  logic [63:0] w_remainder;

  assign w_word = div_op[c_OP_WORD];
  assign w_uns  = div_op[c_OP_UNS];

  assign w_ext1 = !w_word ? src1 :
                  w_uns   ? {32'd0, src1[31:0]} : {{32{src1[31]}}, src1[31:0]};
  assign w_ext2 = !w_word ? src2 :
                  w_uns   ? {32'd0, src2[31:0]} : {{32{src2[31]}}, src2[31:0]};

  assign w_div_zero = (w_ext2 == 64'd0);
  assign w_ovf      = !w_uns & (w_word ? ((src1[31:0] == c_MIN32) && (src2[31:0] == 32'hFFFF_FFFF))
                                       : ((src1 == c_MIN64) && (src2 == c_ONES64)));
  assign w_special  = w_div_zero | w_ovf;

  // Divide-by-zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
  assign w_spec_sel = div_op[c_OP_REM] ? (w_div_zero ? w_ext1 : 64'd0)
                                       : (w_div_zero ? c_ONES64 : w_ext1);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_BUSY) | (r_state == S_DONE);
  assign result    = r_result;
  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_div_rst = ~rst | r_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_BUSY;
      S_BUSY: if (w_q_valid) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op        <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_result    <= '0;
      r_div_valid <= 1'b0;
      r_flush     <= 1'b0;
    end else begin
      r_flush     <= flush;
      r_div_valid <= w_accept & ~w_special;
      if (w_accept) begin
        r_op   <= div_op;
        r_src1 <= w_ext1;
        r_src2 <= w_ext2;
      end
      if (w_accept & w_special) begin
        r_result <= word_fix(w_word, w_spec_sel);
      end else if ((r_state == S_BUSY) && w_q_valid) begin
        r_result <= word_fix(r_op[c_OP_WORD], r_op[c_OP_REM] ? w_remainder : w_quotient);
      end
    end
  end

  ysyx_040750_radix2_div u_div (
    .clk       (clk),
    .rst       (w_div_rst),
    .div_valid (r_div_valid),
    .is_signed (~r_op[c_OP_UNS]),
    .dividend  (r_src1),
    .divisor   (r_src2),
    .Q_valid   (w_q_valid),
    .quotient  (w_quotient),
    .remainder (w_remainder)
  );

endmodule
`default_nettype wire
